// File: rtl/ram_pkg.sv
// Shared sizing and controller state encoding for the 32x4 RAM front end.
// No latency, no backpressure: declarations only.
package ram_pkg;

    localparam int DEF_DW = 4;
    localparam int DEF_AW = 5;
    localparam int DEPTH  = 2 ** DEF_AW;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Zero-fills the RAM after reset or clr, then issues one registered RAM command per accepted request.
// Latency: read accepted at edge N responds on rsp_valid after edge N+2; writes commit at edge N+1.
// Backpressure: req_ready low during fill and while clr is high; responses cannot be stalled.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_w,
    input  logic [DW-1:0] ram_dout
);

    // Counter carries one extra bit so the cycle after the last fill write is distinguishable.
    localparam logic [AW:0] FILL_END = {1'b1, {AW{1'b0}}};

    state_t      state;
    logic [AW:0] cnt;
    logic        rd1;
    logic        rd2;
    logic        accept;

    assign req_ready = (state == RUN) && !clr;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            rd1       <= 1'b0;
            rd2       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
            ram_w     <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            // Read flags keep shifting through clr so earlier reads still respond.
            rd1       <= accept && !req_we;
            rd2       <= rd1;
            rsp_valid <= rd2;
            if (rd2) begin
                rsp_rdata <= ram_dout;
            end

            if (state == INIT) begin
                if (cnt == FILL_END) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                    ram_w     <= 1'b0;
                    cnt       <= '0;
                end else begin
                    ram_w    <= 1'b1;
                    ram_addr <= cnt[AW-1:0];
                    ram_din  <= '0;
                    cnt      <= cnt + (AW+1)'(1);
                end
            end else begin
                if (clr) begin
                    state     <= INIT;
                    init_done <= 1'b0;
                    cnt       <= '0;
                    ram_w     <= 1'b0;
                end else if (accept) begin
                    ram_w    <= req_we;
                    ram_addr <= req_addr;
                    ram_din  <= req_wdata;
                end else begin
                    ram_w <= 1'b0;
                end
            end
        end
    end

endmodule
